// File: rtl/link_frame_rx.sv
// Receive-side framer for the inter-board pong link.
// Assembles HEADER, D0..D3, CHK byte frames from the UART receiver into
// checked 32-bit state words and tracks link health in game-frame ticks.
module link_frame_rx #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned LINK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] frame,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        link_up
);

    localparam int TMO_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(BYTE_TIMEOUT);
    localparam logic [LINK_W-1:0] LINK_LIMIT = LINK_W'(LINK_TIMEOUT);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        shift_q, shift_d;
    logic [7:0]         xor_q, xor_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_inc;
    logic [31:0]        frame_q, frame_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [7:0]         err_count_q, err_count_d;
    logic [LINK_W-1:0]  link_q, link_d;

    logic               tmo_expire;
    logic               chk_byte;
    logic               chk_ok;
    logic               accept;
    logic               reject;

    // Frame-level events shared by the next-state and output logic.
    // A byte arriving in the expiry cycle wins, so expiry requires !rx_valid.
    assign tmo_inc    = tmo_q + TMO_W'(1);
    assign tmo_expire = (state_q != HUNT) && !rx_valid && (tmo_inc == TMO_LIMIT);
    assign chk_byte   = (state_q == CHECK) && rx_valid;
    assign chk_ok     = (rx_data == xor_q) && shift_q[0];
    assign accept     = chk_byte && chk_ok;
    assign reject     = (chk_byte && !chk_ok) || tmo_expire;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: hunt for HEADER, collect four data bytes, test CHK.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (rx_valid && (rx_data == HEADER)) state_d = DATA;
            end
            DATA: begin
                if (rx_valid && (idx_q == 2'd3)) state_d = CHECK;
                else if (tmo_expire)             state_d = HUNT;
            end
            CHECK: begin
                // The CHK byte always returns to HUNT, never counts as a header.
                if (rx_valid || tmo_expire) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    // Datapath and output next values: byte capture, running XOR,
    // inter-byte timer, accepted word, pulses, error count and link timer.
    always_comb begin
        idx_d       = idx_q;
        shift_d     = shift_q;
        xor_d       = xor_q;
        tmo_d       = tmo_q;
        frame_d     = frame_q;
        valid_d     = accept;
        err_d       = reject;
        err_count_d = err_count_q;
        link_d      = link_q;

        if (state_q == HUNT) begin
            idx_d = 2'd0;
            xor_d = 8'h00;
            tmo_d = '0;
        end else begin
            tmo_d = rx_valid ? '0 : tmo_inc;
        end

        if ((state_q == DATA) && rx_valid) begin
            shift_d[{idx_q, 3'b000} +: 8] = rx_data;
            xor_d = xor_q ^ rx_data;
            idx_d = idx_q + 2'd1;
        end

        if (accept) begin
            frame_d = shift_q;
        end

        if (reject && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        // A good frame reloads the timer even when a tick lands in the same cycle.
        if (accept) begin
            link_d = '0;
        end else if (timing_tick && (link_q != LINK_LIMIT)) begin
            link_d = link_q + LINK_W'(1);
        end
    end

    // Datapath and output registers; a reset drops any partial frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 2'd0;
            shift_q     <= 32'h0;
            xor_q       <= 8'h00;
            tmo_q       <= '0;
            frame_q     <= 32'h0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
            link_q      <= LINK_LIMIT;
        end else begin
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            xor_q       <= xor_d;
            tmo_q       <= tmo_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            link_q      <= link_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_count   = err_count_q;
    assign link_up     = (link_q < LINK_LIMIT);

endmodule

// File: tb/tb_link_frame_rx.sv
// Self-checking bench for link_frame_rx: directed scenarios plus randomized
// traffic, compared every cycle against a byte-queue reference model.
module tb_link_frame_rx;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         BT  = 200;
    localparam int         LT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] frame;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        link_up;

    always #5 clk = ~clk;

    link_frame_rx #(
        .HEADER       (HDR),
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .link_up     (link_up)
    );

    int checks = 0;
    int errors = 0;
    int tick_rate = 0;

    // Reference model: bytes gathered since the last header, idle cycles
    // since the last byte, and the ticks seen since the last good frame.
    logic [7:0]  m_bytes[$];
    bit          m_in_frame = 1'b0;
    int          m_idle = 0;
    logic [31:0] m_frame = 32'h0;
    bit          m_fv = 1'b0;
    bit          m_fe = 1'b0;
    int          m_errs = 0;
    int          m_ticks = LT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reject();
        m_fe = 1'b1;
        if (m_errs < 255) m_errs++;
        m_in_frame = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit t);
        bit         good;
        logic [7:0] sum;
        logic [7:0] d0;
        good = 1'b0;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (r) begin
            m_in_frame = 1'b0;
            m_bytes.delete();
            m_idle  = 0;
            m_frame = 32'h0;
            m_errs  = 0;
            m_ticks = LT;
            return;
        end
        if (!m_in_frame) begin
            if (v && d == HDR) begin
                m_in_frame = 1'b1;
                m_bytes.delete();
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_bytes.size() < 4) begin
                m_bytes.push_back(d);
            end else begin
                sum = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
                d0  = m_bytes[0];
                if (d == sum && d0[0]) begin
                    m_frame = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_fv = 1'b1;
                    good = 1'b1;
                    m_in_frame = 1'b0;
                end else begin
                    model_reject();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == BT) model_reject();
        end
        if (good) m_ticks = 0;
        else if (t && m_ticks < LT) m_ticks++;
    endtask

    // One clock: drive at the negedge, update the model at the posedge,
    // then compare all outputs at the following negedge.
    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit t);
        rst = r;
        rx_valid = v;
        rx_data = d;
        timing_tick = t;
        @(posedge clk);
        model_step(r, v, d, t);
        @(negedge clk);
        check("frame", frame, m_frame);
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("frame_err", 32'(frame_err), 32'(m_fe));
        check("err_count", 32'(err_count), 32'(m_errs));
        check("link_up", 32'(link_up), 32'(m_ticks < LT));
    endtask

    function automatic bit rnd_tick();
        if (tick_rate == 0) return 1'b0;
        return ($urandom_range(tick_rate - 1) == 0);
    endfunction

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'($urandom), rnd_tick());
    endtask

    // Sends HEADER, the four little-endian data bytes and CHK xor chk_mask.
    // jitter: random 0..jitter idle cycles between bytes; gap idle cycles
    // are inserted before byte gap_pos (-1 for none).
    task automatic send_word(input logic [31:0] w, input logic [7:0] chk_mask,
                             input int jitter, input int gap_pos, input int gap,
                             input bit tick_last);
        logic [7:0] b[6];
        b[0] = HDR;
        for (int i = 0; i < 4; i++) b[i+1] = w[8*i +: 8];
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ chk_mask;
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && jitter > 0) idle($urandom_range(jitter));
            if (i == gap_pos) idle(gap);
            cyc(1'b0, 1'b1, b[i], (i == 5) ? (tick_last || rnd_tick()) : rnd_tick());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         kind;
        logic [31:0] w;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        timing_tick = 1'b0;
        @(negedge clk);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_frame", frame, 32'h0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        check("rst_link", 32'(link_up), 32'd0);
        idle(2);

        // Basic good frame.
        send_word(32'h04030201, 8'h00, 0, -1, 0, 1'b0);
        check("t1_frame", frame, 32'h04030201);
        check("t1_valid", 32'(frame_valid), 32'd1);
        check("t1_link", 32'(link_up), 32'd1);
        check("t1_count", 32'(err_count), 32'd0);
        idle(1);
        check("t1_pulse_len", 32'(frame_valid), 32'd0);

        // Bad checksum (CHK = 05), then a good frame.
        send_word(32'h04030201, 8'h01, 0, -1, 0, 1'b0);
        check("badchk_err", 32'(frame_err), 32'd1);
        check("badchk_valid", 32'(frame_valid), 32'd0);
        check("badchk_frame", frame, 32'h04030201);
        check("badchk_count", 32'(err_count), 32'd1);
        send_word(32'h0A0B0C0D, 8'h00, 0, -1, 0, 1'b0);
        check("after_bad_valid", 32'(frame_valid), 32'd1);
        check("after_bad_frame", frame, 32'h0A0B0C0D);

        // Marker bit clear.
        send_word(32'h00000002, 8'h00, 0, -1, 0, 1'b0);
        check("marker_err", 32'(frame_err), 32'd1);
        check("marker_frame", frame, 32'h0A0B0C0D);
        check("marker_count", 32'(err_count), 32'd2);

        // Byte timeout after a partial frame.
        cyc(1'b0, 1'b1, HDR, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        idle(BT - 1);
        check("tmo_early", 32'(frame_err), 32'd0);
        idle(1);
        check("tmo_err", 32'(frame_err), 32'd1);
        check("tmo_count", 32'(err_count), 32'd3);
        send_word(32'h45332211, 8'h00, 0, -1, 0, 1'b0);
        check("tmo_recover_valid", 32'(frame_valid), 32'd1);
        check("tmo_recover_frame", frame, 32'h45332211);

        // CHK arriving in the last allowed cycle is accepted.
        send_word(32'h87654321, 8'h00, 0, 5, BT - 1, 1'b0);
        check("tmo_edge_valid", 32'(frame_valid), 32'd1);
        check("tmo_edge_frame", frame, 32'h87654321);

        // HEADER values inside the data are plain data.
        send_word(32'hA5A5A5A5, 8'h00, 0, -1, 0, 1'b0);
        check("hdr_data_frame", frame, 32'hA5A5A5A5);

        // A rejected CHK equal to HEADER does not start a frame.
        send_word(32'h04030201, 8'hA1, 0, -1, 0, 1'b0);
        check("chk_hdr_err", 32'(frame_err), 32'd1);
        check("chk_hdr_count", 32'(err_count), 32'd4);
        send_word(32'h0F0E0D0B, 8'h00, 0, -1, 0, 1'b0);
        check("chk_hdr_next_frame", frame, 32'h0F0E0D0B);

        // Link loss after four ticks without a good frame.
        idle(2);
        repeat (3) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            idle(1);
        end
        check("link_3ticks", 32'(link_up), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("link_4ticks", 32'(link_up), 32'd0);
        check("link_hold_frame", frame, 32'h0F0E0D0B);
        idle(1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("link_stays_down", 32'(link_up), 32'd0);
        send_word(32'h13572469, 8'h00, 0, -1, 0, 1'b1);
        check("link_tick_frame", 32'(link_up), 32'd1);
        check("link_tick_valid", 32'(frame_valid), 32'd1);

        // Reset in the middle of a frame.
        cyc(1'b0, 1'b1, HDR, 1'b0);
        cyc(1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b0, 1'b1, 8'h02, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_count", 32'(err_count), 32'd0);
        check("midrst_frame", frame, 32'h0);
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_link", 32'(link_up), 32'd0);
        cyc(1'b0, 1'b1, 8'h03, 1'b0);
        cyc(1'b0, 1'b1, 8'h04, 1'b0);
        cyc(1'b0, 1'b1, 8'h04, 1'b0);
        check("midrst_no_err", 32'(frame_err), 32'd0);

        // Leading garbage, then a good frame, then saturation.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 1'b1, 8'h7E, 1'b0);
        send_word(32'hC0FFEE11, 8'h00, 0, -1, 0, 1'b0);
        check("garbage_frame", frame, 32'hC0FFEE11);
        check("garbage_valid", 32'(frame_valid), 32'd1);
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            send_word(w | 32'h1, 8'($urandom_range(1, 255)), 0, -1, 0, 1'b0);
        end
        check("sat_count", 32'(err_count), 32'd255);
        check("sat_frame", frame, 32'hC0FFEE11);

        // Randomized traffic with random ticks.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        tick_rate = 6;
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(3));
            w = $urandom;
            case (kind)
                0: send_word(w | 32'h1, 8'h00, 2, -1, 0, 1'b0);
                1: send_word(w, 8'($urandom), 2, -1, 0, 1'b0);
                2: repeat ($urandom_range(1, 4))
                       cyc(1'b0, 1'($urandom_range(1)), 8'($urandom), rnd_tick());
                default: send_word(w | 32'h1, 8'h00, 1, int'($urandom_range(1, 5)),
                                   int'($urandom_range(BT - 3, BT + 2)), 1'b0);
            endcase
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_frame_rx.md
# link_frame_rx

Receive-side framer for the inter-board pong link. It sits between the UART byte receiver and the game logic that consumes the remote game state. It assembles the serial byte stream into checked 32-bit state words (`{y_pad[9:0], y_ball[9:0], x_ball[10:0], marker}`) and presents the last good word with a one-cycle strobe. It also reports link health so the game can freeze on loss of the peer.

## Interface
- `HEADER`, 8'hA5: start-of-frame byte.
- `BYTE_TIMEOUT`, 50000: maximum clk cycles between bytes inside a frame before the frame is abandoned.
- `LINK_TIMEOUT`, 4: number of `timing_tick` pulses without a good frame before `link_up` drops.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `timing_tick`, input, 1: one-cycle game-frame tick, the same tick the game controllers use.
- `rx_data`, input, 8: byte from the UART receiver.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `frame`, output, 32: last accepted state word.
- `frame_valid`, output, 1: one-cycle pulse; `frame` was updated in this cycle.
- `frame_err`, output, 1: one-cycle pulse on a rejected frame.
- `err_count`, output, 8: saturating count of rejected frames.
- `link_up`, output, 1: a good frame has arrived within the last `LINK_TIMEOUT` ticks.

## Operation
- Wire format is 6 bytes:
  - `HEADER`.
  - Data bytes D0..D3, little-endian: D0 = `frame[7:0]`, D3 = `frame[31:24]`.
  - CHK = D0^D1^D2^D3.
- States:
  - HUNT: ignore every byte except `HEADER`. On `rx_valid` with `rx_data==HEADER`, go to DATA, set idx=0 and clear the running XOR.
  - DATA: on each `rx_valid`, write the byte into shift register slot idx and XOR it into the running sum. Increment idx. After D3 (idx==3), go to CHECK.
  - CHECK: on `rx_valid`, compare `rx_data` with the running XOR. Also test the marker bit (D0 bit 0) for 1.
    - Both correct: load `frame` from the shift register, pulse `frame_valid`, reload the link timer.
    - Either wrong: pulse `frame_err` and increment `err_count`, saturating at 255.
    - Either way, return to HUNT.
- A `HEADER` value arriving in DATA or CHECK is treated as an ordinary data or checksum byte; there is no mid-frame resync.
- A rejected checksum byte is never reinterpreted as a header, even when it equals `HEADER`.
- Byte timeout:
  - A clk counter runs in DATA and CHECK and clears on every `rx_valid`.
  - When it reaches `BYTE_TIMEOUT`: go to HUNT, pulse `frame_err`, increment `err_count`.
  - If `rx_valid` arrives in the same cycle, the byte wins: it is processed and there is no timeout.
- Link timer:
  - Counts `timing_tick` pulses since the last good frame.
  - `link_up`=1 while the count is < `LINK_TIMEOUT`. At `LINK_TIMEOUT` it holds (no wrap) and `link_up`=0.
  - A good frame and a `timing_tick` in the same cycle: the count reloads to 0; the good frame wins.
- On link loss `frame` holds its last value; consumers decide what to do.
- Width rules:
  - idx is 2 bits.
  - The byte-timeout counter is sized for `BYTE_TIMEOUT`.
  - The link counter is sized for `LINK_TIMEOUT`.
  - All are unsigned.

## Timing
- Reset values:
  - state = HUNT.
  - `frame` = 32'h0.
  - `frame_valid` = 0, `frame_err` = 0.
  - `err_count` = 0.
  - `link_up` = 0; the link counter is preset to `LINK_TIMEOUT`.
- Latency: `frame` and `frame_valid` update on the clock edge after the CHK-byte `rx_valid` cycle, i.e. valid 1 cycle later. `frame_err` has the same latency.
- `frame_valid` and `frame_err` are registered, never both high, and each lasts exactly 1 cycle.
- `link_up` rises in the same cycle `frame_valid` is high. It falls the cycle after the `LINK_TIMEOUT`-th tick without a good frame.
- `rst` asserted mid-frame discards the partial frame. There is no `frame_err` pulse and `err_count` returns to 0.
- Back-to-back frames need no idle gap: a `HEADER` byte may arrive on the cycle after the CHK byte.

## Test plan
- Reset, then send A5, 01, 02, 03, 04, 04 -> one cycle later `frame`=32'h04030201 with `frame_valid`=1; `link_up`=1; `err_count`=0.
- Send A5, 01, 02, 03, 04, 05 (bad CHK) -> `frame_err` pulse; `frame` unchanged; `err_count`=1. The following good frame is accepted.
- Send A5, 02, 00, 00, 00, 02 (marker bit 0) -> `frame_err`; `frame` unchanged.
- Send A5, 11, then silence for `BYTE_TIMEOUT` cycles -> `frame_err` and return to HUNT. Then send A5, 11, 22, 33, 45, CHK -> accepted, proving the partial bytes were discarded.
- After a good frame, give 4 `timing_tick` with no traffic -> `link_up` falls after the 4th tick and `frame` is held. A good frame coinciding with a tick -> `link_up`=1.
- Leading garbage 00, FF, 7E before a valid frame, then 300 bad frames -> the good frame is decoded; `err_count` saturates at 255.
